clock_period_meter: RTL and testbench
=====================================

CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on sig_in (legal range 2..3).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port sig_in, input, 1 bit: the generated clock under measurement, asynchronous to clk.
REQ-005 The block SHALL have port meas_ready, input, 1 bit: consumer accepts the current result.
REQ-006 The block SHALL have port meas_valid, output, 1 bit: result registers hold an unconsumed measurement.
REQ-007 The block SHALL have port period, output, 7 bits: measured period in clk cycles.
REQ-008 The block SHALL have port high_time, output, 7 bits: measured high phase in clk cycles.
REQ-009 The block SHALL have port ovf, output, 1 bit: the result is a timeout (saturated) measurement.
REQ-010 The block SHALL have port missed, output, 1 bit: sticky flag, a result was overwritten before it was accepted.

Function
REQ-011 sig_in SHALL pass through SYNC_STAGES flops and then one history flop; rise = synced & ~hist, fall = ~synced & hist.
REQ-012 The FSM SHALL have states IDLE, HIGH, and LOW.
REQ-013 In IDLE, a rise SHALL load the 7-bit counter to 1 and go to HIGH; other events SHALL be ignored.
REQ-014 In HIGH or LOW, the counter SHALL increment by 1 each cycle with no rise and count < 127.
REQ-015 In HIGH, a fall SHALL capture the counter value into the high-time holding register and go to LOW.
REQ-016 In LOW, a rise SHALL publish a result and reload the counter to 1, going to HIGH (back-to-back measurement, no idle cycle).
  - period = counter value.
  - high_time = held high time.
  - ovf = 0.
REQ-017 A rise seen while in HIGH (fall missed) SHALL be impossible after synchronization; the design SHALL treat it like REQ-016 with high_time = counter.
REQ-018 Timeout: in HIGH or LOW with counter = 127 and no rise this cycle, the block SHALL publish a result and go to IDLE.
  - period = 127 and ovf = 1.
  - high_time = held value if in LOW, or 127 if in HIGH.
REQ-019 A period of exactly 127 SHALL report normally (ovf = 0); a period of 128 or more SHALL time out.
REQ-020 Publishing SHALL write period, high_time and ovf, and set meas_valid = 1 on the following cycle; result latency from the synchronized rise is 1 cycle.
REQ-021 meas_valid SHALL remain 1 and outputs stable until a cycle with meas_ready = 1, after which meas_valid SHALL be 0.
REQ-022 If a publish coincides with meas_valid & ~meas_ready, new data SHALL overwrite, meas_valid SHALL stay 1, and missed SHALL set.
REQ-023 If a publish coincides with meas_valid & meas_ready, the new result SHALL load, meas_valid SHALL stay 1, and missed SHALL NOT set.
REQ-024 missed SHALL clear only on rst.
REQ-025 All arithmetic SHALL be 7-bit unsigned, and the counter SHALL never wrap.

Reset
REQ-026 On rst, the FSM SHALL enter IDLE.
REQ-027 On rst, counter, holding register, period, high_time, ovf, missed and meas_valid SHALL clear to 0.
REQ-028 On rst, synchronizer and history flops SHALL clear to 0.
REQ-029 rst mid-measurement SHALL discard the partial measurement; measuring restarts at the next rise after release.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (2 bits), CNT_W = 7 and CNT_MAX = 7'd127.
REQ-031 The synchronizer and edge detector SHALL be one sub-module, sync_edge_detect, with outputs rise and fall.
REQ-032 The counter, FSM and output registers SHALL reside in clock_period_meter.

Verification
REQ-033 sig_in period 10 clk, high 4, meas_ready tied 1 -> from the second rise onward each result is period = 10, high_time = 4, ovf = 0, with one meas_valid pulse per period.
REQ-034 sig_in period 200, high 100 -> period = 127, high_time = 100, ovf = 1, FSM returns to IDLE, next rise restarts; repeat at 127 -> period = 127, ovf = 0.
REQ-035 sig_in stuck high after one rise -> after 127 cycles result period = 127, high_time = 127, ovf = 1, then no further results.
REQ-036 Period 6, high 3, meas_ready = 0 for 20 cycles -> meas_valid held, latest result shown, missed = 1; release ready -> meas_valid drops the next cycle unless a publish coincides.
REQ-037 rst pulsed in LOW midway through period 12 -> all outputs 0; the first post-reset result appears one full period after the first rise, with period = 12.

Source files
------------

// File: rtl/clock_period_meter_pkg.sv
// Shared types for the clock period meter: counter width/limit and FSM state encoding.
package clock_period_meter_pkg;

  localparam int CNT_W = 7;
  localparam logic [CNT_W-1:0] CNT_MAX = 7'd127;
  localparam logic [CNT_W-1:0] CNT_ONE = 7'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/clock_period_meter_sync_edge_detect.sv
// Synchronizes an asynchronous clock-like input and flags its rising/falling edges.
// Latency: SYNC_STAGES + 1 cycles from sig_in to a one-cycle rise/fall pulse; no backpressure.
module sync_edge_detect
  import clock_period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   hist_q;
  logic                   hist_d;
  logic                   synced;

  always_comb begin
    synced = sync_q[SYNC_STAGES-1];
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    hist_d = synced;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign rise = synced & ~hist_q;
  assign fall = ~synced & hist_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high phase of an async clock in clk cycles; results 1 cycle after the synced rise.
// Result registers hold until meas_ready; an unaccepted result is overwritten and flagged in sticky missed.
module clock_period_meter
  import clock_period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig_in,
  input  logic       meas_ready,
  output logic       meas_valid,
  output logic [6:0] period,
  output logic [6:0] high_time,
  output logic       ovf,
  output logic       missed
);

  logic rise;
  logic fall;

  state_t             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [CNT_W-1:0]   hold_q,   hold_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   high_q,   high_d;
  logic               ovf_q,    ovf_d;
  logic               missed_q, missed_d;
  logic               valid_q,  valid_d;

  logic               pub;
  logic [CNT_W-1:0]   pub_period;
  logic [CNT_W-1:0]   pub_high;
  logic               pub_ovf;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .rst   (rst),
    .sig_in(sig_in),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      ovf_q    <= 1'b0;
      missed_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      period_q <= period_d;
      high_q   <= high_d;
      ovf_q    <= ovf_d;
      missed_q <= missed_d;
      valid_q  <= valid_d;
    end
  end

  // A rise always wins over timeout, so a period of exactly CNT_MAX still reports normally.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    pub        = 1'b0;
    pub_period = cnt_q;
    pub_high   = hold_q;
    pub_ovf    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          cnt_d   = CNT_ONE;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (rise) begin
          pub      = 1'b1;
          pub_high = cnt_q;
          cnt_d    = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
          pub        = 1'b1;
          pub_period = CNT_MAX;
          pub_high   = CNT_MAX;
          pub_ovf    = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (fall) begin
            hold_d  = cnt_q;
            state_d = ST_LOW;
          end
        end
      end
      ST_LOW: begin
        if (rise) begin
          pub     = 1'b1;
          cnt_d   = CNT_ONE;
          state_d = ST_HIGH;
        end else if (cnt_q == CNT_MAX) begin
          pub        = 1'b1;
          pub_period = CNT_MAX;
          pub_ovf    = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    period_d = period_q;
    high_d   = high_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;
    missed_d = missed_q;
    if (pub) begin
      period_d = pub_period;
      high_d   = pub_high;
      ovf_d    = pub_ovf;
      valid_d  = 1'b1;
      if (valid_q && !meas_ready) begin
        missed_d = 1'b1;
      end
    end else if (valid_q && meas_ready) begin
      valid_d = 1'b0;
    end
  end

  assign meas_valid = valid_q;
  assign period     = period_q;
  assign high_time  = high_q;
  assign ovf        = ovf_q;
  assign missed     = missed_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: waveforms are driven cycle by cycle and results checked against hand-computed values.
module tb_clock_period_meter;

  logic       clk;
  logic       rst;
  logic       sig_in;
  logic       meas_ready;
  logic       meas_valid;
  logic [6:0] period;
  logic [6:0] high_time;
  logic       ovf;
  logic       missed;

  int checks;
  int errors;

  logic [6:0] res_per[$];
  logic [6:0] res_hi[$];
  logic       res_ovf[$];
  int         res_cyc[$];

  clock_period_meter #(
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .meas_ready(meas_ready),
    .meas_valid(meas_valid),
    .period    (period),
    .high_time (high_time),
    .ovf       (ovf),
    .missed    (missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst    = 1'b1;
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives ncycles of a periodic waveform starting with its high phase; logs every accepted result.
  task automatic run_wave(input int per, input int hi, input int ncycles);
    res_per.delete();
    res_hi.delete();
    res_ovf.delete();
    res_cyc.delete();
    for (int m = 0; m < ncycles; m++) begin
      @(negedge clk);
      sig_in = ((m % per) < hi);
      @(posedge clk);
      #1;
      if (meas_valid && meas_ready) begin
        res_per.push_back(period);
        res_hi.push_back(high_time);
        res_ovf.push_back(ovf);
        res_cyc.push_back(m);
      end
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    sig_in     = 1'b0;
    meas_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", meas_valid); end
    checks++; if (period !== 7'd0) begin errors++; $display("FAIL reset_period got %0d want 0", period); end
    checks++; if (high_time !== 7'd0) begin errors++; $display("FAIL reset_high got %0d want 0", high_time); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    checks++; if (missed !== 1'b0) begin errors++; $display("FAIL reset_missed got %b want 0", missed); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    apply_reset();
    meas_ready = 1'b1;
    run_wave(10, 4, 60);
    checks++; if (res_per.size() != 5) begin errors++; $display("FAIL basic_count got %0d want 5", res_per.size()); end
    for (int i = 0; i < res_per.size(); i++) begin
      checks++; if (res_per[i] !== 7'd10) begin errors++; $display("FAIL basic_period[%0d] got %0d want 10", i, res_per[i]); end
      checks++; if (res_hi[i] !== 7'd4) begin errors++; $display("FAIL basic_high[%0d] got %0d want 4", i, res_hi[i]); end
      checks++; if (res_ovf[i] !== 1'b0) begin errors++; $display("FAIL basic_ovf[%0d] got %b want 0", i, res_ovf[i]); end
    end
    if (res_cyc.size() > 0) begin
      checks++; if (res_cyc[0] != 12) begin errors++; $display("FAIL basic_latency got cycle %0d want 12", res_cyc[0]); end
    end
    checks++; if (missed !== 1'b0) begin errors++; $display("FAIL basic_missed got %b want 0", missed); end
  endtask

  task automatic test_timeout();
    apply_reset();
    meas_ready = 1'b1;
    run_wave(200, 100, 410);
    checks++; if (res_per.size() != 2) begin errors++; $display("FAIL tmo_count got %0d want 2", res_per.size()); end
    for (int i = 0; i < res_per.size(); i++) begin
      checks++; if (res_per[i] !== 7'd127) begin errors++; $display("FAIL tmo_period[%0d] got %0d want 127", i, res_per[i]); end
      checks++; if (res_hi[i] !== 7'd100) begin errors++; $display("FAIL tmo_high[%0d] got %0d want 100", i, res_hi[i]); end
      checks++; if (res_ovf[i] !== 1'b1) begin errors++; $display("FAIL tmo_ovf[%0d] got %b want 1", i, res_ovf[i]); end
    end
    if (res_cyc.size() == 2) begin
      checks++; if (res_cyc[0] != 129 || res_cyc[1] != 329) begin
        errors++; $display("FAIL tmo_cycles got %0d,%0d want 129,329", res_cyc[0], res_cyc[1]);
      end
    end
  endtask

  task automatic test_period_max();
    apply_reset();
    meas_ready = 1'b1;
    run_wave(127, 60, 300);
    checks++; if (res_per.size() != 2) begin errors++; $display("FAIL max_count got %0d want 2", res_per.size()); end
    for (int i = 0; i < res_per.size(); i++) begin
      checks++; if (res_per[i] !== 7'd127) begin errors++; $display("FAIL max_period[%0d] got %0d want 127", i, res_per[i]); end
      checks++; if (res_hi[i] !== 7'd60) begin errors++; $display("FAIL max_high[%0d] got %0d want 60", i, res_hi[i]); end
      checks++; if (res_ovf[i] !== 1'b0) begin errors++; $display("FAIL max_ovf[%0d] got %b want 0", i, res_ovf[i]); end
    end
  endtask

  task automatic test_stuck_high();
    apply_reset();
    meas_ready = 1'b1;
    run_wave(1000, 1000, 300);
    checks++; if (res_per.size() != 1) begin errors++; $display("FAIL stuck_count got %0d want 1", res_per.size()); end
    if (res_per.size() > 0) begin
      checks++; if (res_per[0] !== 7'd127) begin errors++; $display("FAIL stuck_period got %0d want 127", res_per[0]); end
      checks++; if (res_hi[0] !== 7'd127) begin errors++; $display("FAIL stuck_high got %0d want 127", res_hi[0]); end
      checks++; if (res_ovf[0] !== 1'b1) begin errors++; $display("FAIL stuck_ovf got %b want 1", res_ovf[0]); end
      checks++; if (res_cyc[0] != 129) begin errors++; $display("FAIL stuck_cycle got %0d want 129", res_cyc[0]); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    meas_ready = 1'b0;
    run_wave(6, 3, 20);
    checks++; if (meas_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held got %b want 1", meas_valid); end
    checks++; if (period !== 7'd6) begin errors++; $display("FAIL bp_period got %0d want 6", period); end
    checks++; if (high_time !== 7'd3) begin errors++; $display("FAIL bp_high got %0d want 3", high_time); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf got %b want 0", ovf); end
    checks++; if (missed !== 1'b1) begin errors++; $display("FAIL bp_missed got %b want 1", missed); end
    meas_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (meas_valid !== 1'b1) begin errors++; $display("FAIL bp_coincide_valid got %b want 1", meas_valid); end
    @(posedge clk);
    #1;
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", meas_valid); end
    checks++; if (missed !== 1'b1) begin errors++; $display("FAIL bp_missed_sticky got %b want 1", missed); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    meas_ready = 1'b1;
    run_wave(12, 6, 20);
    checks++; if (res_per.size() != 1) begin errors++; $display("FAIL rmid_pre_count got %0d want 1", res_per.size()); end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", meas_valid); end
    checks++; if (period !== 7'd0) begin errors++; $display("FAIL rmid_period got %0d want 0", period); end
    checks++; if (high_time !== 7'd0) begin errors++; $display("FAIL rmid_high got %0d want 0", high_time); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rmid_ovf got %b want 0", ovf); end
    checks++; if (missed !== 1'b0) begin errors++; $display("FAIL rmid_missed got %b want 0", missed); end
    @(negedge clk);
    rst = 1'b0;
    run_wave(12, 6, 40);
    checks++; if (res_per.size() != 3) begin errors++; $display("FAIL rmid_count got %0d want 3", res_per.size()); end
    if (res_per.size() > 0) begin
      checks++; if (res_cyc[0] != 14) begin errors++; $display("FAIL rmid_first_cycle got %0d want 14", res_cyc[0]); end
      checks++; if (res_per[0] !== 7'd12) begin errors++; $display("FAIL rmid_period got %0d want 12", res_per[0]); end
      checks++; if (res_hi[0] !== 7'd6) begin errors++; $display("FAIL rmid_high got %0d want 6", res_hi[0]); end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    sig_in     = 1'b0;
    meas_ready = 1'b1;
    test_reset();
    test_basic();
    test_timeout();
    test_period_max();
    test_stuck_high();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
